// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: NIN-operand, WIDTH-bit bitwise AND/OR/XOR/NAND unit feeding a DIZ-stage valid/ready pipeline.
// Latency: DIZ cycles from the accept edge to out_valid, plus one cycle for every cycle the pipe is stalled.
// Backpressure: the whole pipe freezes while out_valid & ~out_ready; in_ready = ~out_valid | out_ready. Define GATE_PIPE_COUNT_EN to add beat_count.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int NIN   = 2,
    parameter int DIZ   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             op,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NIN*WIDTH-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_z
`ifdef GATE_PIPE_COUNT_EN
    ,
    output logic [15:0]            beat_count
`endif
);

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    logic [WIDTH-1:0] and_red;
    logic [WIDTH-1:0] or_red;
    logic [WIDTH-1:0] xor_red;
    logic [WIDTH-1:0] z;

    // Front end: reduce all operands bit by bit, then pick the requested operation.
    always_comb begin
        and_red = '1;
        or_red  = '0;
        xor_red = '0;
        for (int k = 0; k < NIN; k++) begin
            and_red = and_red & in_data[k*WIDTH +: WIDTH];
            or_red  = or_red  | in_data[k*WIDTH +: WIDTH];
            xor_red = xor_red ^ in_data[k*WIDTH +: WIDTH];
        end
        z = and_red;
        case (op_e'(op))
            OP_AND:  z = and_red;
            OP_OR:   z = or_red;
            OP_XOR:  z = xor_red;
            OP_NAND: z = ~and_red;
            default: z = and_red;
        endcase
    end

    // Stage s holds {vld_q[s], dat_q[s]}; stage DIZ-1 is the output register.
    logic                  adv;
    logic [DIZ-1:0]        vld_q;
    logic [DIZ-1:0]        vld_d;
    logic [DIZ-1:0][WIDTH-1:0] dat_q;
    logic [DIZ-1:0][WIDTH-1:0] dat_d;

    // One global advance: bubbles shift like beats, so nothing is squeezed out.
    assign adv       = ~vld_q[DIZ-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[DIZ-1];
    assign out_z     = dat_q[DIZ-1];

    // Next stage contents: shift everything by one place on advance, otherwise hold.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (adv) begin
            vld_d[0] = in_valid;
            dat_d[0] = z;
            for (int s = 1; s < DIZ; s++) begin
                vld_d[s] = vld_q[s-1];
                dat_d[s] = dat_q[s-1];
            end
        end
    end

    // Pipeline registers; reset clears every stage so no beat survives it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

`ifdef GATE_PIPE_COUNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Count beats leaving the unit, sticking at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Transfer counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign beat_count = cnt_q;
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Bench for logic_gate_pipe: random and directed streams checked against a beat-age scoreboard.
// The scoreboard tracks each accepted beat by how many advancing cycles it has seen.
// Optional GATE_PIPE_COUNT_EN checks of beat_count are compiled in when the macro is defined.
module tb_logic_gate_pipe;

    localparam int W   = 8;
    localparam int NIN = 3;
    localparam int DIZ = 3;

    logic               clk;
    logic               reset;
    logic [1:0]         op;
    logic               in_valid;
    logic               in_ready;
    logic [NIN*W-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_z;
`ifdef GATE_PIPE_COUNT_EN
    logic [15:0]        beat_count;
`endif

    logic_gate_pipe #(.WIDTH(W), .NIN(NIN), .DIZ(DIZ)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z)
`ifdef GATE_PIPE_COUNT_EN
        ,
        .beat_count(beat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference result from per-bit counts of set operand bits.
    function automatic logic [W-1:0] ref_z(input logic [1:0] o, input logic [NIN*W-1:0] d);
        logic [W-1:0] r;
        int ones;
        r = '0;
        for (int b = 0; b < W; b++) begin
            ones = 0;
            for (int k = 0; k < NIN; k++) ones += int'(d[k*W+b]);
            case (o)
                2'b00:   r[b] = (ones == NIN);
                2'b01:   r[b] = (ones != 0);
                2'b10:   r[b] = ((ones % 2) == 1);
                default: r[b] = (ones != NIN);
            endcase
        end
        return r;
    endfunction

    // Scoreboard: each accepted beat with the number of advancing edges it has seen.
    typedef struct {
        logic [W-1:0] d;
        int           age;
    } beat_t;

    beat_t       mq[$];
    int          cyc = 0;
    logic [15:0] mcnt = 16'd0;
    bit          mon_en = 1'b0;

    function automatic bit m_vld();
        return (mq.size() > 0) && (mq[0].age == DIZ);
    endfunction

    always @(posedge clk) begin
        bit madv;
        beat_t nb;
        cyc++;
        if (reset) begin
            mq.delete();
            mcnt = 16'd0;
        end else begin
            madv = !m_vld() || out_ready;
            if (madv) begin
                foreach (mq[i]) mq[i].age++;
                if (mq.size() > 0 && mq[0].age > DIZ) begin
                    void'(mq.pop_front());
                    if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
                end
                if (in_valid) begin
                    nb.d   = ref_z(op, in_data);
                    nb.age = 1;
                    mq.push_back(nb);
                end
            end
        end
    end

    int xfer_cnt   = 0;
    int first_xfer = 0;
    int last_xfer  = 0;

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("out_valid", 32'(out_valid), 32'(m_vld()));
            chk("in_ready", 32'(in_ready), 32'(!m_vld() || out_ready));
            if (m_vld()) chk("out_z", 32'(out_z), 32'(mq[0].d));
`ifdef GATE_PIPE_COUNT_EN
            chk("beat_count", 32'(beat_count), 32'(mcnt));
`endif
            if (out_valid && out_ready) begin
                if (xfer_cnt == 0) first_xfer = cyc;
                last_xfer = cyc;
                xfer_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One directed beat, then check it shows for exactly one cycle, DIZ cycles later.
    task automatic directed(input logic [1:0] o, input logic [NIN*W-1:0] d,
                            input logic [W-1:0] expz, input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = o;
        in_data   = d;
        step();
        in_valid  = 1'b0;
        op        = 2'($urandom());
        in_data   = (NIN*W)'($urandom());
        for (int k = 1; k <= DIZ + 1; k++) begin
            @(negedge clk);
            chk({tag, "_vld"}, 32'(out_valid), 32'(k == DIZ));
            if (k == DIZ) chk(tag, 32'(out_z), 32'(expz));
            step();
        end
    endtask

    // mode 0: full rate; mode 1: out_ready low on stream cycles 3..6; mode 2: random.
    task automatic run_stream(input int nbeats, input int mode);
        int sent;
        int c;
        bit acc;
        sent = 0;
        c    = 0;
        while (sent < nbeats && c < nbeats * 4 + 50) begin
            in_valid  = (mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
            out_ready = (mode == 1) ? !(c >= 3 && c <= 6)
                      : (mode == 2) ? ($urandom_range(2) != 0) : 1'b1;
            op        = 2'($urandom());
            in_data   = (NIN*W)'($urandom());
            #3;
            if (mode == 1 && c >= 3 && c <= 6) chk("stall_in_ready", 32'(in_ready), 32'd0);
            acc = in_valid && in_ready;
            step();
            if (acc) sent++;
            c++;
        end
        chk("stream_accepts", 32'(sent), 32'(nbeats));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DIZ + 6) step();
    endtask

    initial begin
        int s;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 2'b00;
        in_data   = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_z", 32'(out_z), 32'd0);
        step();
        step();
        reset  = 1'b0;
        mon_en = 1'b1;
        step();

        // T1: reset with beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            op       = 2'($urandom());
            in_data  = (NIN*W)'($urandom());
            step();
        end
        chk("t1_preload_vld", 32'(out_valid), 32'd1);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("t1_async_vld", 32'(out_valid), 32'd0);
        chk("t1_async_z", 32'(out_z), 32'd0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t1_idle_vld", 32'(out_valid), 32'd0);
            step();
        end

        // T2: each operation on A5, 0F, 3C.
        directed(2'b00, {8'h3C, 8'h0F, 8'hA5}, 8'h04, "t2_and");
        directed(2'b01, {8'h3C, 8'h0F, 8'hA5}, 8'hBF, "t2_or");
        directed(2'b10, {8'h3C, 8'h0F, 8'hA5}, 8'h96, "t2_xor");
        directed(2'b11, {8'h3C, 8'h0F, 8'hA5}, 8'hFB, "t2_nand");
        // T3: single AND beat, latency DIZ, valid for one cycle.
        directed(2'b00, {8'hFF, 8'h81, 8'hFF}, 8'h81, "t3_lat");
`ifdef GATE_PIPE_COUNT_EN
        chk("t6_count5", 32'(beat_count), 32'd5);
`endif

        // T4: 10 beats with a four-cycle output stall.
        xfer_cnt = 0;
        run_stream(10, 1);
        chk("t4_xfers", 32'(xfer_cnt), 32'd10);

        // T5: 100 back-to-back beats at full rate.
        xfer_cnt = 0;
        s = cyc;
        run_stream(100, 0);
        chk("t5_xfers", 32'(xfer_cnt), 32'd100);
        chk("t5_first", 32'(first_xfer - s), 32'(DIZ));
        chk("t5_span", 32'(last_xfer - first_xfer), 32'd99);

        // Random traffic.
        xfer_cnt = 0;
        run_stream(300, 2);
        chk("rand_xfers", 32'(xfer_cnt), 32'd300);

`ifdef GATE_PIPE_COUNT_EN
        // T6: preload near saturation and overflow.
        force dut.cnt_q = 16'hFFFD;
        mcnt = 16'hFFFD;
        #1;
        release dut.cnt_q;
        run_stream(6, 0);
        chk("t6_sat", 32'(beat_count), 32'h0000FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
